// File: rtl/pipe_fetch_if.sv
// Instruction-memory fetch channel between the IF stage (master) and imem (slave).
// Latency: none; this is wiring only.
// Backpressure: the memory holds a request off by keeping imem_ready low; the request may be held any number of cycles.
//
// Signals:
//   imem_req   master->slave  fetch request
//   imem_addr  master->slave  fetch address
//   imem_rdata slave->master  instruction word, meaningful when imem_ready is high
//   imem_ready slave->master  imem_rdata is valid this cycle
interface pipe_fetch_if #(
    parameter int WIDTH = 32
);
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic [WIDTH-1:0] imem_rdata;
    logic             imem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ready
    );
endinterface

// File: rtl/pipe_fetch.sv
// Instruction-fetch stage: owns the PC, picks the next PC, fetches over imem and registers the IF/ID boundary.
// Latency: an instruction accepted at edge N is on d_inst/d_valid right after edge N, unless stalled.
// Backpressure: imem wait states insert bubbles; a word that arrives while stalled is parked in a one-entry hold buffer.
//
// Ports:
//   clk, rst          clock (rising edge) and asynchronous active-high reset
//   pcsource          next-PC select: 00 pc+PC_STEP, 01 bpc, 10 rpc, 11 jpc
//   bpc, rpc, jpc     branch / register / jump targets
//   stall, flush      hazard-unit hold and squash/redirect
//   imem              fetch channel (pipe_fetch_if master)
//   pc                current fetch PC
//   d_pc4, d_inst     IF/ID pc+PC_STEP and instruction
//   d_valid, d_flush  IF/ID holds a real instruction; registered copy of flush
//   misalign          misaligned-target fault, only when PIPEIF_ALIGN_CHECK_EN is defined
//
// Build option: define PIPEIF_ALIGN_CHECK_EN to trap misaligned next-PC targets in a FAULT state.
module pipe_fetch #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int unsigned      PC_STEP  = 4,
    parameter logic [WIDTH-1:0] NOP      = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       pcsource,
    input  logic [WIDTH-1:0] bpc,
    input  logic [WIDTH-1:0] rpc,
    input  logic [WIDTH-1:0] jpc,
    input  logic             stall,
    input  logic             flush,
    pipe_fetch_if.master     imem,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] d_pc4,
    output logic [WIDTH-1:0] d_inst,
    output logic             d_valid,
    output logic             d_flush
`ifdef PIPEIF_ALIGN_CHECK_EN
    ,
    output logic             misalign
`endif
);

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    logic [1:0]       state_q,   state_d;
    logic [WIDTH-1:0] pc_q,      pc_d;
    logic [WIDTH-1:0] d_pc4_q,   d_pc4_d;
    logic [WIDTH-1:0] d_inst_q,  d_inst_d;
    logic             d_valid_q, d_valid_d;
    logic             d_flush_q, d_flush_d;
    logic [WIDTH-1:0] hold_q,    hold_d;
`ifdef PIPEIF_ALIGN_CHECK_EN
    logic             misalign_q, misalign_d;
`endif

    logic [WIDTH-1:0] pc_step;
    logic [WIDTH-1:0] npc;
    logic             fire;
    logic             take_npc;

    // Wraps modulo 2^WIDTH by construction.
    assign pc_step = pc_q + WIDTH'(PC_STEP);

    always_comb begin
        npc = pc_step;
        case (pcsource)
            2'b00:   npc = pc_step;
            2'b01:   npc = bpc;
            2'b10:   npc = rpc;
            default: npc = jpc;
        endcase
    end

    // Gated by rst so no request leaks out while reset is held.
    assign imem.imem_req  = (state_q == ST_FETCH) && !rst;
    assign imem.imem_addr = pc_q;
    assign fire           = imem.imem_req && imem.imem_ready;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        d_pc4_d   = d_pc4_q;
        d_inst_d  = d_inst_q;
        d_valid_d = d_valid_q;
        d_flush_d = flush;
        hold_d    = hold_q;
        take_npc  = 1'b0;
`ifdef PIPEIF_ALIGN_CHECK_EN
        misalign_d = misalign_q;
`endif

        if (flush) begin
            // Squash wins over everything: buffered word and any word firing now are dropped.
            take_npc  = 1'b1;
            d_valid_d = 1'b0;
            d_inst_d  = NOP;
            state_d   = ST_FETCH;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (stall) begin
                        // Park a word that arrives during a stall so it is not refetched.
                        if (fire) begin
                            hold_d  = imem.imem_rdata;
                            state_d = ST_HOLD;
                        end
                    end else if (fire) begin
                        d_inst_d  = imem.imem_rdata;
                        d_pc4_d   = pc_step;
                        d_valid_d = 1'b1;
                        take_npc  = 1'b1;
                    end else begin
                        d_valid_d = 1'b0;
                        d_inst_d  = NOP;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        d_inst_d  = hold_q;
                        d_pc4_d   = pc_step;
                        d_valid_d = 1'b1;
                        take_npc  = 1'b1;
                        state_d   = ST_FETCH;
                    end
                end
                ST_FAULT: begin
                    d_valid_d = 1'b0;
                    d_inst_d  = NOP;
                end
                default: begin
                    state_d = ST_FETCH;
                end
            endcase
        end

        if (take_npc) begin
`ifdef PIPEIF_ALIGN_CHECK_EN
            // A misaligned target leaves pc untouched and parks the stage until an aligned flush.
            if (npc[1:0] != 2'b00) begin
                misalign_d = 1'b1;
                state_d    = ST_FAULT;
            end else begin
                pc_d       = npc;
                misalign_d = 1'b0;
            end
`else
            pc_d = npc;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_PC;
            d_pc4_q   <= '0;
            d_inst_q  <= NOP;
            d_valid_q <= 1'b0;
            d_flush_q <= 1'b0;
            hold_q    <= '0;
`ifdef PIPEIF_ALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            d_pc4_q   <= d_pc4_d;
            d_inst_q  <= d_inst_d;
            d_valid_q <= d_valid_d;
            d_flush_q <= d_flush_d;
            hold_q    <= hold_d;
`ifdef PIPEIF_ALIGN_CHECK_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    assign pc      = pc_q;
    assign d_pc4   = d_pc4_q;
    assign d_inst  = d_inst_q;
    assign d_valid = d_valid_q;
    assign d_flush = d_flush_q;
`ifdef PIPEIF_ALIGN_CHECK_EN
    assign misalign = misalign_q;
`endif

endmodule
